// File: rtl/prbs10_checker.sv
// prbs10_checker: receive-side checker for the 10-stage XNOR PRBS
// (b[n] = ~(b[n-7] ^ b[n-10]), period 1023). Hunts for the sequence,
// verifies it for LOCK_BITS bits, then free-runs a local generator and
// counts mismatches against it. Too many errors in one window drops lock.
// Optional feature: define PRBS_CHK_STUCK_EN to detect the all-ones
// XNOR lockup state and report it on `stuck`.
module prbs10_checker #(
    parameter int ERR_W     = 16,
    parameter int LOCK_BITS = 16,
    parameter int WIN_BITS  = 64,
    parameter int LOSS_ERRS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             stuck
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        CHECK  = 2'd2
    } state_e;

    localparam logic [7:0]  LOCK_CNT = 8'(LOCK_BITS);
    localparam logic [15:0] WIN_CNT  = 16'(WIN_BITS);
    localparam logic [15:0] LOSS_CNT = 16'(LOSS_ERRS);

    state_e           state_q, state_d;
    logic [10:1]      sr_q, sr_d;          // sr[1] is the newest bit
    logic [3:0]       fill_q, fill_d;
    logic [7:0]       good_q, good_d;
    logic [15:0]      win_bits_q, win_bits_d;
    logic [15:0]      win_errs_q, win_errs_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             err_pulse_q, err_pulse_d;
    logic             locked_q, locked_d;
    logic             stuck_q, stuck_d;

    logic             pred;
    logic             mismatch;
    logic [10:1]      sr_next;
    logic             sr_all_ones;
    logic [7:0]       good_inc;
    logic [15:0]      bits_inc;
    logic [15:0]      errs_inc;
    logic             err_inc;

    // Local prediction and the shifted register: in CHECK the generator
    // free-runs on its own prediction so a line error is counted only once.
    assign pred     = ~(sr_q[7] ^ sr_q[10]);
    assign mismatch = din ^ pred;
    assign sr_next  = (state_q == CHECK) ? {sr_q[9:1], pred} : {sr_q[9:1], din};
    assign good_inc = good_q + 8'd1;
    assign bits_inc = win_bits_q + 16'd1;
    assign errs_inc = win_errs_q + {15'd0, mismatch};

`ifdef PRBS_CHK_STUCK_EN
    assign sr_all_ones = &sr_next;
`else
    assign sr_all_ones = 1'b0;
`endif

    // Next-state, counter and output logic for the HUNT/VERIFY/CHECK FSM.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        good_d      = good_q;
        win_bits_d  = win_bits_q;
        win_errs_d  = win_errs_q;
        stuck_d     = stuck_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;

        if (din_valid) begin
            sr_d = sr_next;
            unique case (state_q)
                HUNT: begin
                    fill_d = fill_q + 4'd1;
                    if (fill_q == 4'd9) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        good_d  = '0;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else begin
                        good_d = good_inc;
                        if (good_inc == LOCK_CNT) begin
                            state_d    = CHECK;
                            win_bits_d = '0;
                            win_errs_d = '0;
                            stuck_d    = 1'b0;
                        end
                    end
                end
                CHECK: begin
                    err_pulse_d = mismatch;
                    err_inc     = mismatch;
                    if (errs_inc == LOSS_CNT) begin
                        state_d    = HUNT;
                        fill_d     = '0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else if (bits_inc == WIN_CNT) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        win_bits_d = bits_inc;
                        win_errs_d = errs_inc;
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase

            // All-ones is the XNOR lockup state; abandon lock and flag it.
            if (state_q != HUNT && sr_all_ones) begin
                state_d    = HUNT;
                fill_d     = '0;
                win_bits_d = '0;
                win_errs_d = '0;
                stuck_d    = 1'b1;
            end
        end

        // Clear wins over a simultaneous increment; the count saturates.
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (err_inc && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end

        locked_d = (state_d == CHECK);
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
            stuck_q     <= stuck_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign stuck     = stuck_q;

endmodule
